// File: rtl/math_display_mux.sv
// Two-digit multiplexed seven-segment driver for an 8-bit result.
// The shown value is latched once per frame so the two digits never tear.
module math_display_mux #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       hold,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       digit,
  output logic       frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    SHOW_LO = 1'b0,
    SHOW_HI = 1'b1
  } phase_t;

  phase_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shadow;
  logic [6:0]    r_seg;
  logic          r_digit;
  logic          r_frame_pend;
  logic          r_frame;

  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_next;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] res;
    case (nib)
      4'h0:    res = 7'h3F;
      4'h1:    res = 7'h06;
      4'h2:    res = 7'h5B;
      4'h3:    res = 7'h4F;
      4'h4:    res = 7'h66;
      4'h5:    res = 7'h6D;
      4'h6:    res = 7'h7D;
      4'h7:    res = 7'h07;
      4'h8:    res = 7'h7F;
      4'h9:    res = 7'h6F;
      4'hA:    res = 7'h77;
      4'hB:    res = 7'h7C;
      4'hC:    res = 7'h39;
      4'hD:    res = 7'h5E;
      4'hE:    res = 7'h79;
      4'hF:    res = 7'h71;
      default: res = 7'h00;
    endcase
    return res;
  endfunction

  // Next segment pattern from the current phase and latched value.
  always_comb begin
    w_wrap     = (r_cnt == CNT_MAX);
    w_nibble   = 4'h0;
    w_seg_next = 7'h00;
    if (r_phase == SHOW_HI) begin
      w_nibble = r_shadow[7:4];
    end else begin
      w_nibble = r_shadow[3:0];
    end
    if ((r_phase == SHOW_HI) && blank_lz && (r_shadow[7:4] == 4'h0)) begin
      w_seg_next = 7'h00;
    end else begin
      w_seg_next = seg7_decode(w_nibble);
    end
  end

  // Refresh counter, phase FSM, frame capture and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase      <= SHOW_LO;
      r_cnt        <= '0;
      r_shadow     <= 8'h00;
      r_seg        <= 7'h00;
      r_digit      <= 1'b0;
      r_frame_pend <= 1'b0;
      r_frame      <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_digit      <= (r_phase == SHOW_HI);
      // frame follows the capture by one edge so it lines up with the
      // first segment pattern drawn from the newly latched value
      r_frame      <= r_frame_pend;
      r_frame_pend <= 1'b0;
      if (w_wrap) begin
        r_cnt <= '0;
        case (r_phase)
          SHOW_LO: r_phase <= SHOW_HI;
          SHOW_HI: begin
            r_phase      <= SHOW_LO;
            r_frame_pend <= 1'b1;
            if (!hold) begin
              r_shadow <= value;
            end else begin
              r_shadow <= r_shadow;
            end
          end
          default: r_phase <= SHOW_LO;
        endcase
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign seg   = r_seg;
  assign digit = r_digit;
  assign frame = r_frame;

endmodule
